// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path (scan front end and decoder).
package seg_pkg;
  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] digit_sel_t;

  localparam digit_sel_t LAST_SEL = digit_sel_t'(NUM_DIGITS - 1);

  // Pick nibble n out of a packed four-digit word.
  function automatic bcd_t digit_at(input logic [15:0] word, input digit_sel_t n);
    return word[{n, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and raises tick for the single cycle at DIV-1.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  // NOTE: state is updated with <= so all flops sample their inputs from the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_scan.sv
// Four-digit display scanner: shadow/active double buffer committed at frame wrap,
// one digit per refresh tick, registered select/data/dp outputs.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dps,
  output logic [1:0]  select,
  output logic [3:0]  data,
  output logic        dp,
  output logic        pending,
  output logic        frame_done
);
  logic tick;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  digit_sel_t  select_q, select_d;
  logic [15:0] act_digits_q, act_digits_d;
  logic [3:0]  act_dps_q, act_dps_d;
  logic [15:0] sh_digits_q, sh_digits_d;
  logic [3:0]  sh_dps_q, sh_dps_d;
  logic        pending_q, pending_d;
  bcd_t        data_q, data_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic wrap, commit;

  always_comb begin
    wrap   = tick && (select_q == LAST_SEL);
    commit = wrap && pending_q;

    select_d     = tick ? select_q + 1'b1 : select_q;
    act_digits_d = commit ? sh_digits_q : act_digits_q;
    act_dps_d    = commit ? sh_dps_q    : act_dps_q;

    // A load coinciding with a commit lands in the shadow after the old one moves out.
    sh_digits_d = load ? digits : sh_digits_q;
    sh_dps_d    = load ? dps    : sh_dps_q;
    pending_d   = load ? 1'b1 : (commit ? 1'b0 : pending_q);

    // Outputs are built from next-state values so select and data/dp move together.
    data_d       = digit_at(act_digits_d, select_d);
    dp_d         = act_dps_d[select_d];
    frame_done_d = wrap;
  end

  // NOTE: the shadow and active registers are reset too, so an interrupted update is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      select_q     <= '0;
      act_digits_q <= '0;
      act_dps_q    <= '0;
      sh_digits_q  <= '0;
      sh_dps_q     <= '0;
      pending_q    <= 1'b0;
      data_q       <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      select_q     <= select_d;
      act_digits_q <= act_digits_d;
      act_dps_q    <= act_dps_d;
      sh_digits_q  <= sh_digits_d;
      sh_dps_q     <= sh_dps_d;
      pending_q    <= pending_d;
      data_q       <= data_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign select     = select_q;
  assign data       = data_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (DIV=4): frame-level reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_seg_scan;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dps = '0;
  logic [1:0]  select;
  logic [3:0]  data;
  logic        dp;
  logic        pending;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  seg_scan #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .digits    (digits),
    .dps       (dps),
    .select    (select),
    .data      (data),
    .dp        (dp),
    .pending   (pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset release decide the scan position; the display
  // buffer swaps only at whole-frame boundaries.
  int          m_edges;
  logic [15:0] m_act_digits, m_sh_digits;
  logic [3:0]  m_act_dps, m_sh_dps;
  logic        m_pending;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges      <= 0;
      m_act_digits <= '0;
      m_act_dps    <= '0;
      m_sh_digits  <= '0;
      m_sh_dps     <= '0;
      m_pending    <= 1'b0;
    end else begin
      automatic int k = m_edges + 1;
      automatic logic [15:0] ad = m_act_digits;
      automatic logic [3:0]  ap = m_act_dps;
      automatic logic [15:0] sd = m_sh_digits;
      automatic logic [3:0]  sp = m_sh_dps;
      automatic logic        pd = m_pending;
      if (k % FRAME == 0 && pd) begin
        ad = sd;
        ap = sp;
        pd = 1'b0;
      end
      if (load) begin
        sd = digits;
        sp = dps;
        pd = 1'b1;
      end
      m_edges      <= k;
      m_act_digits <= ad;
      m_act_dps    <= ap;
      m_sh_digits  <= sd;
      m_sh_dps     <= sp;
      m_pending    <= pd;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      automatic int         sel = (m_edges / DIV) % 4;
      automatic logic [3:0] nib = 4'((m_act_digits >> (4 * sel)) & 16'hF);
      automatic logic       fd  = (m_edges > 0) && (m_edges % FRAME == 0);
      check("model_select",     32'(select),     32'(sel));
      check("model_data",       32'(data),       32'(nib));
      check("model_dp",         32'(dp),         32'(m_act_dps[sel]));
      check("model_pending",    32'(pending),    32'(m_pending));
      check("model_frame_done", 32'(frame_done), 32'(fd));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    load   = 1'b1;
    digits = d;
    dps    = p;
    step();
    load   = 1'b0;
  endtask

  task automatic wait_sel(input logic [1:0] target);
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      if (select == target) return;
    end
    check("wait_sel_timeout", 32'(select), 32'(target));
  endtask

  task automatic wait_frame(output int cycles);
    cycles = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      cycles++;
      if (frame_done) return;
    end
    check("wait_frame_timeout", 32'(frame_done), 32'd1);
  endtask

  int n;

  initial begin
    // Scenario: reset, then no load.
    #12;
    check("rst_select",     32'(select),     32'd0);
    check("rst_data",       32'(data),       32'd0);
    check("rst_pending",    32'(pending),    32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_frame(n);
    check("first_frame_cycles", 32'(n), 32'(FRAME));
    check("first_wrap_sel", 32'(select), 32'd0);
    wait_frame(n);
    check("frame_period", 32'(n), 32'(FRAME));

    // Scenario: load while select==1, committed at the wrap.
    wait_sel(2'd1);
    do_load(16'h4321, 4'b0100);
    check("s2_pending_rise", 32'(pending), 32'd1);
    check("s2_data_held",    32'(data),    32'd0);
    wait_frame(n);
    check("s2_sel0_data", 32'(data),    32'd1);
    check("s2_sel0_dp",   32'(dp),      32'd0);
    check("s2_pend_clr",  32'(pending), 32'd0);
    wait_sel(2'd1);
    check("s2_sel1_data", 32'(data), 32'd2);
    wait_sel(2'd2);
    check("s2_sel2_data", 32'(data), 32'd3);
    check("s2_sel2_dp",   32'(dp),   32'd1);
    wait_sel(2'd3);
    check("s2_sel3_data", 32'(data), 32'd4);
    check("s2_sel3_dp",   32'(dp),   32'd0);

    // Scenario: two loads in one frame; the last one wins.
    wait_frame(n);
    do_load(16'h1111, 4'b0000);
    step();
    do_load(16'h9999, 4'b0000);
    wait_frame(n);
    check("s3_data9",   32'(data),    32'd9);
    check("s3_pending", 32'(pending), 32'd0);

    // Scenario: load on the commit cycle while 2222 is pending.
    do_load(16'h2222, 4'b0000);
    wait_sel(2'd3);
    repeat (DIV - 1) step();
    do_load(16'h5555, 4'b0000);
    check("s4_wrap",    32'(frame_done), 32'd1);
    check("s4_data2",   32'(data),       32'd2);
    check("s4_pending", 32'(pending),    32'd1);
    wait_frame(n);
    check("s4_data5",     32'(data),    32'd5);
    check("s4_pend_clr",  32'(pending), 32'd0);

    // Scenario: reset mid-frame with a load pending.
    wait_sel(2'd2);
    do_load(16'h7777, 4'b1111);
    step();
    rst_n = 1'b0;
    #1;
    check("s5_rst_select",  32'(select),  32'd0);
    check("s5_rst_data",    32'(data),    32'd0);
    check("s5_rst_dp",      32'(dp),      32'd0);
    check("s5_rst_pending", 32'(pending), 32'd0);
    step();
    rst_n = 1'b1;
    wait_frame(n);
    check("s5_after_data",    32'(data),    32'd0);
    check("s5_after_pending", 32'(pending), 32'd0);

    // Scenario: non-BCD nibbles pass through.
    do_load(16'hFEDC, 4'b1000);
    wait_frame(n);
    check("s6_sel0", 32'(data), 32'hC);
    wait_sel(2'd1);
    check("s6_sel1", 32'(data), 32'hD);
    wait_sel(2'd2);
    check("s6_sel2", 32'(data), 32'hE);
    wait_sel(2'd3);
    check("s6_sel3", 32'(data), 32'hF);
    check("s6_dp3",  32'(dp),   32'd1);
    repeat (FRAME) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexing front end for the four-digit seven-segment display: holds four BCD digits plus decimal points and steps one digit per refresh tick, driving the decoder stage's `select`, `data` and `dp` inputs. A host loads new display contents with a single-cycle pulse. The new contents are committed only at a frame boundary, so a partial update never appears on the display.

## Interface
Parameters:
- `DIV`, default 50000: clock cycles per digit slot (refresh tick period); legal range ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  single-cycle request to capture `digits`/`dps` into the shadow register.
- `digits`  in  16  four BCD nibbles; [3:0] is digit 0, [15:12] is digit 3.
- `dps`  in  4  decimal point per digit; bit n belongs to digit n; 1 lights the point.
- `select`  out  2  active digit index; feeds the decoder's select input.
- `data`  out  4  BCD nibble of the active digit.
- `dp`  out  1  decimal point of the active digit.
- `pending`  out  1  shadow register holds contents not yet committed.
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- Prescaler counts 0..DIV-1 and wraps. `tick` is high for exactly one cycle when the count equals DIV-1.
- On `tick`, `select` advances: 0→1→2→3→0. Outside a tick, `select` holds.
- `data`/`dp` always equal the active-register nibble/bit indexed by `select`. They are registered and change on the same edge as `select`, so there is never a cycle with a mismatched pair.
- Shadow register (16+4 bits): on `load`, it captures `digits`/`dps` and sets `pending`. A second `load` before commit overwrites the shadow; the last load wins.
- Commit happens on the tick where `select` is 3 and `pending` is 1:
  - the active register takes the shadow contents and `pending` clears;
  - the new contents appear with `select`=0 on the same edge.
- `frame_done` pulses on every 3→0 wrap, whether or not a commit occurs.
- `load` in the same cycle as a commit:
  - the commit uses the old shadow;
  - the shadow then takes the new inputs and `pending` stays 1;
  - the new inputs are committed at the next wrap.
- Non-BCD nibbles (A–F) pass through unchanged; their rendering is decided downstream.

## Timing
- Reset values: prescaler 0, `select` 0, active digits 0, active dps 0, shadow 0, `pending` 0, `frame_done` 0, `data` 0, `dp` 0.
- Reset asserted mid-frame or mid-update returns every register to its reset value immediately and asynchronously. Any pending load is discarded.
- First tick after reset release occurs DIV cycles after the first active edge. A digit slot is DIV cycles long; a frame is 4×DIV cycles.
- `pending` rises one cycle after `load` is sampled.
- Load-to-display latency is from 1 cycle to 4×DIV cycles after `pending` rises, depending on scan phase.
- `frame_done`, the `select` wrap to 0 and the commit all occur on the same edge.
- No backpressure: `load` is always accepted.

## Structure
- Package `seg_pkg`:
  - constant `NUM_DIGITS` = 4;
  - typedef `bcd_t` (logic [3:0]);
  - typedef `digit_sel_t` (logic [1:0]).
  - `seg_pkg` is shared with the decoder stage.
- Sub-module `tick_gen`, parameterised by `DIV`: prescaler counter producing the one-cycle `tick`; reusable for debounce/blink timers.
- Top holds the `select` counter, shadow and active registers, `pending` flag and output muxing.

## Test plan
All scenarios run with `DIV`=4.
- Reset then no load: `select` steps 0,1,2,3,0 every 4 cycles; `data`=0 and `dp`=0 throughout; `frame_done` pulses every 16 cycles on the 3→0 edge.
- `load` with `digits`=16'h4321 and `dps`=4'b0100 while `select`=1: `pending`=1 next cycle. Display stays 0 until the 3→0 wrap. Then `select`=0,1,2,3 shows `data`=1,2,3,4 with `dp` high only at `select`=2, and `pending` clears.
- Two loads in one frame (16'h1111, then 16'h9999): after the wrap the display shows 9 on all digits; 1 never appears.
- `load` of 16'h5555 on the commit cycle while 16'h2222 is pending: the next frame shows 2s with `pending` still 1; the frame after that shows 5s and `pending` clears.
- `rst_n` low for 1 cycle mid-frame with a load pending: all outputs return to reset values at once; after release the display stays 0 and `pending`=0.
- `load` with 16'hFEDC: A–F nibbles appear verbatim on `data` in order C,D,E,F.
